div: RTL



---
 rtl/div_pkg.sv | 38 +++
 rtl/div.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helpers for the iterative RV32M divider.
package div_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OP_W  = 3;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [OP_W-1:0] OP_DIV  = 3'b100;
   localparam logic [OP_W-1:0] OP_DIVU = 3'b101;
   localparam logic [OP_W-1:0] OP_REM  = 3'b110;
   localparam logic [OP_W-1:0] OP_REMU = 3'b111;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
   localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   function automatic logic op_is_signed(input logic [OP_W-1:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(input logic [OP_W-1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Two's-complement negate when neg is set; magnitude of INT_MIN stays 0x80000000.
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

endpackage

// File: rtl/div.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU; holds the pipeline while
// a division is in flight and releases it in the result cycle.
module div
   import div_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            div_start_i,
   input  logic [OP_W-1:0] div_op_i,
   input  logic [XLEN-1:0] div_dividend_i,
   input  logic [XLEN-1:0] div_divisor_i,
   input  logic [RD_W-1:0] div_rd_addr_i,
   input  logic            div_flush_i,
   output logic            div_hold_req_o,
   output logic            div_busy_o,
   output logic            div_ready_o,
   output logic [XLEN-1:0] div_result_o,
   output logic [RD_W-1:0] div_rd_addr_o
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             rem_sel_q, rem_sel_d;
   logic [RD_W-1:0]  rd_q, rd_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [RD_W-1:0]  rd_out_q, rd_out_d;
   logic             hold_c;

   logic            op_signed;
   logic            op_rem;
   logic            dvd_neg;
   logic            dvs_neg;
   logic [XLEN-1:0] dvd_mag;
   logic [XLEN-1:0] dvs_mag;
   logic            div_zero;
   logic            overflow;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;

   // Operand decode: magnitudes and result sign rules for the incoming instruction.
   assign op_signed = op_is_signed(div_op_i);
   assign op_rem    = op_is_rem(div_op_i);
   assign dvd_neg   = op_signed & div_dividend_i[XLEN-1];
   assign dvs_neg   = op_signed & div_divisor_i[XLEN-1];
   assign dvd_mag   = cond_neg(div_dividend_i, dvd_neg);
   assign dvs_mag   = cond_neg(div_divisor_i, dvs_neg);
   assign div_zero  = (div_divisor_i == '0);
   assign overflow  = op_signed & (div_dividend_i == INT_MIN) & (div_divisor_i == ALL_ONES);

   // Trial subtract: bit XLEN set means the shifted remainder is below the divisor.
   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      rem_sel_d = rem_sel_q;
      rd_d      = rd_q;
      result_d  = '0;
      rd_out_d  = '0;
      hold_c    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (div_start_i) begin
               hold_c    = 1'b1;
               rd_d      = div_rd_addr_i;
               rem_sel_d = op_rem;
               neg_quo_d = dvd_neg ^ dvs_neg;
               neg_rem_d = dvd_neg;
               if (div_zero) begin
                  state_d  = ST_DONE;
                  result_d = op_rem ? div_dividend_i : ALL_ONES;
                  rd_out_d = div_rd_addr_i;
               end else if (overflow) begin
                  state_d  = ST_DONE;
                  result_d = op_rem ? '0 : INT_MIN;
                  rd_out_d = div_rd_addr_i;
               end else begin
                  state_d = ST_CALC;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = dvd_mag;
                  dvs_d   = dvs_mag;
               end
            end
         end
         ST_CALC: begin
            hold_c = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (!trial[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = shifted[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == LAST_ITER) begin
               state_d  = ST_DONE;
               result_d = rem_sel_q ? cond_neg(rem_d, neg_rem_q) : cond_neg(quo_d, neg_quo_q);
               rd_out_d = rd_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flush wins in every state: abandon the operation and any pending result.
      if (div_flush_i) begin
         state_d  = ST_IDLE;
         hold_c   = 1'b0;
         result_d = '0;
         rd_out_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rem_sel_q <= 1'b0;
         rd_q      <= '0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         rem_sel_q <= rem_sel_d;
         rd_q      <= rd_d;
         result_q  <= result_d;
         rd_out_q  <= rd_out_d;
      end
   end

   // Hold is combinational so the start cycle itself is frozen; it is forced low in reset.
   assign div_hold_req_o = rst_n & hold_c;
   assign div_busy_o     = (state_q != ST_IDLE);
   assign div_ready_o    = (state_q == ST_DONE);
   assign div_result_o   = result_q;
   assign div_rd_addr_o  = rd_out_q;

endmodule
